// File: rtl/signed_buffer_window_pkg.sv
// signed_buffer_window_pkg
// Shared definitions for the signed sample history / sliding-window controller:
//   - FSM state encoding (S_FILL, S_STREAM)
//   - fill_cnt_w(): width of a counter that holds 0..depth
//   - start_legal(): whether a window start offset fits inside the history
package signed_buffer_window_pkg;

    typedef logic [0:0] win_state_t;

    localparam win_state_t S_FILL   = 1'b0;
    localparam win_state_t S_STREAM = 1'b1;

    function automatic int fill_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic start_legal(input int start, input int slice, input int depth);
        return (start + slice) <= depth;
    endfunction

endpackage

// File: rtl/signed_history_shift_reg.sv
// signed_history_shift_reg
// Per-channel signed shift history. Entry 0 holds the newest sample; on each
// shift_en every entry moves one slot older and the oldest is discarded.
// Ports:
//   clk       system clock
//   rstb      synchronous active-low reset, clears the whole history to 0
//   shift_en  shift in_data into entry 0 this cycle
//   in_data   numChannels signed samples
//   hist      hist[ch][k], k = 0 newest .. buff_depth-1 oldest
module signed_history_shift_reg #(
    parameter int numChannels = 16,
    parameter int bitwidth    = 8,
    parameter int buff_depth  = 5
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       shift_en,
    input  logic signed [bitwidth-1:0] in_data [numChannels],
    output logic signed [bitwidth-1:0] hist    [numChannels][buff_depth]
);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int ch = 0; ch < numChannels; ch++) begin
                for (int k = 0; k < buff_depth; k++) begin
                    hist[ch][k] <= '0;
                end
            end
        end else if (shift_en) begin
            for (int ch = 0; ch < numChannels; ch++) begin
                hist[ch][0] <= in_data[ch];
                for (int k = 1; k < buff_depth; k++) begin
                    hist[ch][k] <= hist[ch][k-1];
                end
            end
        end
    end

endmodule

// File: rtl/signed_buffer_window_ctrl.sv
// signed_buffer_window_ctrl
// Sequencing controller for the per-channel signed sample history and its
// sliding-window readout. Accepted sample vectors shift into a buff_depth-deep
// history; once enough entries exist to cover [start_q, start_q+slice_depth),
// every accept presents one flattened window downstream with valid/ready.
// Optional build macro: WINDOW_DROP_CNT_EN adds the drop_cnt output.
// Ports:
//   clk, rstb            clock, synchronous active-low reset
//   in_data/in_valid     upstream sample vector and its valid
//   in_ready             sample accepted this cycle when in_valid is high
//   cfg_start/cfg_load   window start offset and its one-cycle apply strobe
//   flush                one-cycle strobe: discard history, restart window
//   flat_slice           flat_slice[d*numChannels+ch] = hist[ch][start_q+d]
//   out_valid/out_ready  downstream handshake for flat_slice
//   cfg_err              sticky flag: an illegal cfg_start was rejected
//   fill_cnt             accepted entries, saturating at buff_depth
//   drop_cnt             (WINDOW_DROP_CNT_EN) cycles with in_valid & !in_ready
module signed_buffer_window_ctrl
    import signed_buffer_window_pkg::*;
#(
    parameter int numChannels   = 16,
    parameter int bitwidth      = 8,
    parameter int buff_depth    = 5,
    parameter int slice_depth   = 3,
    parameter int start_default = 0
) (
    input  logic                                 clk,
    input  logic                                 rstb,
    input  logic signed [bitwidth-1:0]           in_data [numChannels],
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [$clog2(buff_depth)-1:0]        cfg_start,
    input  logic                                 cfg_load,
    input  logic                                 flush,
    output logic signed [bitwidth-1:0]           flat_slice [numChannels*slice_depth],
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 cfg_err,
    output logic [$clog2(buff_depth+1)-1:0]      fill_cnt
`ifdef WINDOW_DROP_CNT_EN
    ,
    output logic [15:0]                          drop_cnt
`endif
);

    localparam int SW = $clog2(buff_depth);
    localparam int FW = fill_cnt_w(buff_depth);
    // One extra bit so start_q + slice_depth never truncates.
    localparam int NW = FW + 1;

    localparam logic [FW-1:0] FILL_FULL = FW'(buff_depth);
    localparam logic [NW-1:0] SLICE_N   = NW'(slice_depth);
    localparam logic [SW-1:0] START0    = SW'(start_default);

    logic signed [bitwidth-1:0] hist [numChannels][buff_depth];
    logic [SW-1:0]              start_q;
    win_state_t                 state;
    logic                       accept;
    logic [FW-1:0]              fill_next;
    logic [NW-1:0]              need;
    logic                       reach;

    assign in_ready = rstb & ~flush & ~cfg_load & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    signed_history_shift_reg #(
        .numChannels (numChannels),
        .bitwidth    (bitwidth),
        .buff_depth  (buff_depth)
    ) u_hist (
        .clk      (clk),
        .rstb     (rstb),
        .shift_en (accept),
        .in_data  (in_data),
        .hist     (hist)
    );

    always_comb begin
        fill_next = fill_cnt;
        if (accept && (fill_cnt != FILL_FULL)) begin
            fill_next = fill_cnt + 1'b1;
        end
        need  = {{(NW-SW){1'b0}}, start_q} + SLICE_N;
        reach = ({1'b0, fill_next} >= need);
    end

    // start_q is always legal, so start_q+d stays inside the history.
    for (genvar d = 0; d < slice_depth; d++) begin : g_d
        for (genvar ch = 0; ch < numChannels; ch++) begin : g_ch
            assign flat_slice[d*numChannels+ch] = hist[ch][start_q + SW'(d)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            fill_cnt  <= '0;
            start_q   <= START0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
            state     <= S_FILL;
        end else if (cfg_load) begin
            // An illegal offset still restarts the window, like a flush.
            if (start_legal(int'(cfg_start), slice_depth, buff_depth)) begin
                start_q <= cfg_start;
            end else begin
                cfg_err <= 1'b1;
            end
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            state     <= S_FILL;
        end else if (flush) begin
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            state     <= S_FILL;
        end else begin
            fill_cnt <= fill_next;
            if (accept) begin
                // Once streaming, fill only grows, so every accept is a window.
                out_valid <= (state == S_STREAM) | reach;
                if (reach) begin
                    state <= S_STREAM;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef WINDOW_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstb) begin
            drop_cnt <= '0;
        end else if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_signed_buffer_window_ctrl.sv
module tb_signed_buffer_window_ctrl;

    logic              clk;
    logic              rstb;
    logic signed [7:0] in_data [16];
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        cfg_start;
    logic              cfg_load;
    logic              flush;
    logic signed [7:0] flat_slice [48];
    logic              out_valid;
    logic              out_ready;
    logic              cfg_err;
    logic [2:0]        fill_cnt;
`ifdef WINDOW_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    signed_buffer_window_ctrl #(
        .numChannels   (16),
        .bitwidth      (8),
        .buff_depth    (5),
        .slice_depth   (3),
        .start_default (0)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_start  (cfg_start),
        .cfg_load   (cfg_load),
        .flush      (flush),
        .flat_slice (flat_slice),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cfg_err    (cfg_err),
        .fill_cnt   (fill_cnt)
`ifdef WINDOW_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Reference model state
    logic signed [7:0] mh [16][5];
    int                mstart = 0;
    int                mfill  = 0;
    bit                mvalid = 1'b0;
    logic [383:0]      exp_q [$];

    function automatic logic signed [7:0] dval(input int n, input int ch);
        return 8'(ch + 10 * n);
    endfunction

    function automatic bit exp_ready();
        return (rstb === 1'b1) && !flush && !cfg_load && (!mvalid || out_ready);
    endfunction

    function automatic logic [383:0] mwin();
        logic [383:0] w;
        w = '0;
        for (int d = 0; d < 3; d++)
            for (int ch = 0; ch < 16; ch++)
                w[(d*16+ch)*8 +: 8] = mh[ch][mstart+d];
        return w;
    endfunction

    function automatic logic [383:0] dwin();
        logic [383:0] w;
        for (int i = 0; i < 48; i++) w[i*8 +: 8] = flat_slice[i];
        return w;
    endfunction

    task automatic drive(input bit v, input int n, input bit ordy, input bit fl,
                         input bit ld, input int cs);
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        cfg_load  = ld;
        cfg_start = 3'(cs);
        for (int ch = 0; ch < 16; ch++)
            in_data[ch] = (n < 0) ? 8'($urandom) : dval(n, ch);
        #1;
    endtask

    // Advance one clock and update the reference model.
    task automatic step();
        bit acc;
        acc = in_valid && exp_ready();
        @(posedge clk);
        if (rstb !== 1'b1) begin
            for (int ch = 0; ch < 16; ch++)
                for (int k = 0; k < 5; k++) mh[ch][k] = '0;
            mstart = 0; mfill = 0; mvalid = 1'b0; exp_q.delete();
        end else if (cfg_load) begin
            if (int'(cfg_start) + 3 <= 5) mstart = int'(cfg_start);
            mfill = 0; mvalid = 1'b0; exp_q.delete();
        end else if (flush) begin
            mfill = 0; mvalid = 1'b0; exp_q.delete();
        end else if (acc) begin
            for (int ch = 0; ch < 16; ch++) begin
                for (int k = 4; k > 0; k--) mh[ch][k] = mh[ch][k-1];
                mh[ch][0] = in_data[ch];
            end
            if (mfill < 5) mfill++;
            mvalid = (mfill >= mstart + 3);
            if (mvalid) exp_q.push_back(mwin());
        end else if (out_ready) begin
            mvalid = 1'b0;
        end
        #1;
    endtask

    // Scoreboard monitor: handshake signals and consumed windows.
    always @(negedge clk) begin
        if (mon_en) begin
            n_chk++;
            if (in_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL mon_in_ready t=%0t: got %b want %b", $time, in_ready, exp_ready());
            end else n_pass++;
            n_chk++;
            if (out_valid !== mvalid) begin
                n_fail++;
                $display("FAIL mon_out_valid t=%0t: got %b want %b", $time, out_valid, mvalid);
            end else n_pass++;
            if (mvalid && out_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mon_window t=%0t: got window want empty scoreboard", $time);
                end else begin
                    logic [383:0] e;
                    e = exp_q.pop_front();
                    if (dwin() !== e) begin
                        n_fail++;
                        $display("FAIL mon_window t=%0t: got %h want %h", $time, dwin(), e);
                    end else n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        rstb = 1'b0;
        drive(1, 1, 0, 0, 0, 0);
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end else n_pass++;
        step(); step();
        n_chk++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end else n_pass++;
        n_chk++;
        if (fill_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_fill: got %0d want 0", fill_cnt); end else n_pass++;
        n_chk++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_err: got %b want 0", cfg_err); end else n_pass++;
        n_chk++;
        if (dwin() !== 384'd0) begin n_fail++; $display("FAIL rst_window: got %h want 0", dwin()); end else n_pass++;
        rstb = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_fill();
        for (int n = 1; n <= 3; n++) begin
            drive(1, n, 0, 0, 0, 0);
            step();
            if (n == 2) begin
                n_chk++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_early_valid: got %b want 0", out_valid); end else n_pass++;
            end
        end
        n_chk++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b want 1", out_valid); end else n_pass++;
        n_chk++;
        if (fill_cnt !== 3'd3) begin n_fail++; $display("FAIL fill_cnt3: got %0d want 3", fill_cnt); end else n_pass++;
        n_chk++;
        if (flat_slice[0] !== 8'sd30 || flat_slice[16] !== 8'sd20 || flat_slice[32] !== 8'sd10) begin
            n_fail++;
            $display("FAIL fill_layout: got %0d,%0d,%0d want 30,20,10", flat_slice[0], flat_slice[16], flat_slice[32]);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            drive(1, 4, 0, 0, 0, 0);
            n_chk++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end else n_pass++;
            n_chk++;
            if (exp_q.size() == 0 || dwin() !== exp_q[0]) begin
                n_fail++; $display("FAIL bp_hold: got %h want held window", dwin());
            end else n_pass++;
            step();
        end
        n_chk++;
        if (fill_cnt !== 3'd3) begin n_fail++; $display("FAIL bp_fill: got %0d want 3", fill_cnt); end else n_pass++;
        drive(1, 4, 1, 0, 0, 0);
        step();
        drive(0, 0, 1, 0, 0, 0);
        step();
        n_chk++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL bp_drain: got valid %b pending %0d want 0 0", out_valid, exp_q.size());
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive(1, -1, 1, 0, 0, 0);
            step();
        end
        n_chk++;
        if (fill_cnt !== 3'd5) begin n_fail++; $display("FAIL b2b_fill_sat: got %0d want 5", fill_cnt); end else n_pass++;
        drive(0, 0, 1, 0, 0, 0);
        step();
    endtask

    task automatic test_cfg_load();
        drive(1, 0, 1, 0, 1, 2);
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_in_ready: got %b want 0", in_ready); end else n_pass++;
        step();
        n_chk++;
        if (fill_cnt !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL cfg_restart: got fill %0d valid %b want 0 0", fill_cnt, out_valid);
        end else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(1, 11 + i, 0, 0, 0, 0);
            step();
            if (i == 3) begin
                n_chk++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cfg_early_valid: got %b want 0", out_valid); end else n_pass++;
            end
        end
        n_chk++;
        if (out_valid !== 1'b1 || flat_slice[0] !== dval(13, 0)) begin
            n_fail++; $display("FAIL cfg_window: got valid %b d0 %0d want 1 %0d", out_valid, flat_slice[0], dval(13, 0));
        end else n_pass++;
        drive(0, 0, 1, 0, 0, 0);
        step();
    endtask

    task automatic test_cfg_err();
        drive(0, 0, 1, 0, 1, 3);
        step();
        n_chk++;
        if (cfg_err !== 1'b1 || fill_cnt !== 3'd0) begin
            n_fail++; $display("FAIL err_flag: got err %b fill %0d want 1 0", cfg_err, fill_cnt);
        end else n_pass++;
        for (int i = 0; i < 5; i++) begin
            drive(1, 21 + i, 0, 0, 0, 0);
            step();
        end
        n_chk++;
        if (out_valid !== 1'b1 || flat_slice[0] !== dval(23, 0)) begin
            n_fail++; $display("FAIL err_start_kept: got valid %b d0 %0d want 1 %0d", out_valid, flat_slice[0], dval(23, 0));
        end else n_pass++;
    endtask

    task automatic test_flush_load();
        drive(1, 30, 1, 1, 1, 0);
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_in_ready: got %b want 0", in_ready); end else n_pass++;
        step();
        n_chk++;
        if (fill_cnt !== 3'd0 || out_valid !== 1'b0 || cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL fl_restart: got fill %0d valid %b err %b want 0 0 1", fill_cnt, out_valid, cfg_err);
        end else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(1, 31 + i, 0, 0, 0, 0);
            step();
        end
        n_chk++;
        if (flat_slice[0] !== dval(33, 0) || flat_slice[32] !== dval(31, 0)) begin
            n_fail++; $display("FAIL fl_start0: got %0d,%0d want %0d,%0d", flat_slice[0], flat_slice[32], dval(33, 0), dval(31, 0));
        end else n_pass++;
        drive(0, 0, 0, 1, 0, 0);
        step();
        n_chk++;
        if (fill_cnt !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_only: got fill %0d valid %b want 0 0", fill_cnt, out_valid);
        end else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive(1, -1, 1, 0, 0, 0);
            step();
        end
    endtask

    task automatic test_reset_midstream();
        rstb = 1'b0;
        drive(1, 40, 0, 0, 0, 0);
        step();
        n_chk++;
        if (out_valid !== 1'b0 || fill_cnt !== 3'd0 || cfg_err !== 1'b0 || dwin() !== 384'd0) begin
            n_fail++; $display("FAIL mid_reset: got valid %b fill %0d err %b want 0 0 0 and empty window", out_valid, fill_cnt, cfg_err);
        end else n_pass++;
        rstb = 1'b1;
    endtask

`ifdef WINDOW_DROP_CNT_EN
    task automatic test_drop_cnt();
        for (int n = 1; n <= 3; n++) begin
            drive(1, n, 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 7; i++) begin
            drive(1, 50, 0, 0, 0, 0);
            step();
        end
        n_chk++;
        if (drop_cnt !== 16'd7) begin n_fail++; $display("FAIL drop_cnt7: got %0d want 7", drop_cnt); end else n_pass++;
        rstb = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        n_chk++;
        if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL drop_rst: got %0d want 0", drop_cnt); end else n_pass++;
        rstb = 1'b1;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        test_reset();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_cfg_load();
        test_cfg_err();
        test_flush_load();
        test_reset_midstream();
`ifdef WINDOW_DROP_CNT_EN
        test_drop_cnt();
`endif
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
